// File: rtl/rot_pkg.sv
// Shared definitions for the rotary quadrature decoder: FSM state
// encoding, the detent rest code and the direction encodings.
package rot_pkg;

    // Decoder FSM states; RESYNC is the all-ones code and the reset state.
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        CW1    = 3'b001,
        CW2    = 3'b010,
        CW3    = 3'b011,
        CCW1   = 3'b100,
        CCW2   = 3'b101,
        CCW3   = 3'b110,
        RESYNC = 3'b111
    } rot_state_e;

    // Filtered {A,B} value while the encoder rests in a detent.
    localparam logic [1:0] REST_CODE = 2'b00;

    // rotation_dir encodings.
    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

endpackage

// File: rtl/rot_debounce.sv
// Single-pin front end: two-flop synchroniser followed by a stability
// filter. With ROT_DEBOUNCE_EN defined the filtered value only follows the
// synchronised value after DEBOUNCE_CYCLES consecutive differing samples;
// without it the filtered value is the synchronised value.
module rot_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic filt_o
);

    logic sync1_q;
    logic sync2_q;

    // Two-stage synchroniser; idles high like an undriven encoder pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef ROT_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             filt_q;
    logic             filt_d;

    // Count consecutive disagreeing samples; accept the new level at the limit.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync2_q == filt_q) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
            filt_d = sync2_q;
            cnt_d  = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Filter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= CNT_ZERO;
            filt_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt_o = filt_q;
`else
    // Debounce length has no effect when the filter is not built.
    logic [31:0] unused_dc_s;
    assign unused_dc_s = 32'(DEBOUNCE_CYCLES);

    assign filt_o = sync2_q;
`endif

endmodule

// File: rtl/rot_quad_decoder.sv
// Rotary quadrature decoder: synchronises/debounces ROT_A and ROT_B and
// decodes full Gray-code detent cycles into single-cycle rotation events,
// a held direction flag and a wrapping position count. Two-bit filtered
// jumps raise seq_error and park the FSM in RESYNC until the rest code.
// Optional feature macro: ROT_DEBOUNCE_EN (enables the debounce counters).
module rot_quad_decoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int POS_WIDTH       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ROT_A,
    input  logic                 ROT_B,
    output logic                 rotation_event,
    output logic                 rotation_dir,
    output logic [POS_WIDTH-1:0] position,
    output logic                 seq_error
);

    import rot_pkg::*;

    localparam logic [POS_WIDTH-1:0] POS_STEP = POS_WIDTH'(1'b1);
    localparam logic [POS_WIDTH-1:0] POS_ZERO = {POS_WIDTH{1'b0}};

    logic                 a_filt_s;
    logic                 b_filt_s;
    logic [1:0]           ab_s;
    rot_state_e           state_q;
    rot_state_e           state_d;
    logic                 event_q;
    logic                 event_d;
    logic                 dir_q;
    logic                 dir_d;
    logic [POS_WIDTH-1:0] pos_q;
    logic [POS_WIDTH-1:0] pos_d;
    logic                 err_q;
    logic                 err_d;

    rot_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_i  (ROT_A),
        .filt_o (a_filt_s)
    );

    rot_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_i  (ROT_B),
        .filt_o (b_filt_s)
    );

    assign ab_s = {a_filt_s, b_filt_s};

    // Next-state decode; events and errors are produced on the transition itself.
    always_comb begin
        state_d = state_q;
        event_d = 1'b0;
        err_d   = 1'b0;
        dir_d   = dir_q;
        pos_d   = pos_q;
        case (state_q)
            IDLE: begin
                case (ab_s)
                    2'b10:   state_d = CW1;
                    2'b01:   state_d = CCW1;
                    2'b11:   begin state_d = RESYNC; err_d = 1'b1; end
                    default: state_d = IDLE;
                endcase
            end
            CW1: begin
                case (ab_s)
                    2'b11:     state_d = CW2;
                    REST_CODE: state_d = IDLE;
                    2'b01:     begin state_d = RESYNC; err_d = 1'b1; end
                    default:   state_d = CW1;
                endcase
            end
            CW2: begin
                case (ab_s)
                    2'b01:     state_d = CW3;
                    2'b10:     state_d = CW1;
                    REST_CODE: begin state_d = RESYNC; err_d = 1'b1; end
                    default:   state_d = CW2;
                endcase
            end
            CW3: begin
                case (ab_s)
                    REST_CODE: begin
                        state_d = IDLE;
                        event_d = 1'b1;
                        dir_d   = DIR_CW;
                        pos_d   = pos_q + POS_STEP;
                    end
                    2'b11:   state_d = CW2;
                    2'b10:   begin state_d = RESYNC; err_d = 1'b1; end
                    default: state_d = CW3;
                endcase
            end
            CCW1: begin
                case (ab_s)
                    2'b11:     state_d = CCW2;
                    REST_CODE: state_d = IDLE;
                    2'b10:     begin state_d = RESYNC; err_d = 1'b1; end
                    default:   state_d = CCW1;
                endcase
            end
            CCW2: begin
                case (ab_s)
                    2'b10:     state_d = CCW3;
                    2'b01:     state_d = CCW1;
                    REST_CODE: begin state_d = RESYNC; err_d = 1'b1; end
                    default:   state_d = CCW2;
                endcase
            end
            CCW3: begin
                case (ab_s)
                    REST_CODE: begin
                        state_d = IDLE;
                        event_d = 1'b1;
                        dir_d   = DIR_CCW;
                        pos_d   = pos_q - POS_STEP;
                    end
                    2'b11:   state_d = CCW2;
                    2'b01:   begin state_d = RESYNC; err_d = 1'b1; end
                    default: state_d = CCW3;
                endcase
            end
            RESYNC: begin
                if (ab_s == REST_CODE) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESYNC;
                end
            end
            default: state_d = RESYNC;
        endcase
    end

    // State and output registers; reset parks in RESYNC so power-up mid-detent is silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESYNC;
            event_q <= 1'b0;
            dir_q   <= 1'b0;
            pos_q   <= POS_ZERO;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            event_q <= event_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
        end
    end

    assign rotation_event = event_q;
    assign rotation_dir   = dir_q;
    assign position       = pos_q;
    assign seq_error      = err_q;

endmodule

// File: tb/tb_rot_quad_decoder.sv
// Self-checking bench for rot_quad_decoder. Expectations follow the
// ROT_DEBOUNCE_EN build setting (debounce latency and glitch behaviour).
module tb_rot_quad_decoder;

    localparam int DC   = 16;
    localparam int PW   = 4;
`ifdef ROT_DEBOUNCE_EN
    localparam int LAT  = DC + 2;
    localparam int GLITCH_EVENTS = 0;
`else
    localparam int LAT  = 2;
    localparam int GLITCH_EVENTS = 1;
`endif
    localparam int HOLD = 24;

    typedef struct {
        logic [15:0] seq;
        int          len;
        int          ev;
        int          err;
        int          dpos;
        logic        dir;
    } vec_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          rot_a = 1'b1;
    logic          rot_b = 1'b1;
    logic          rotation_event;
    logic          rotation_dir;
    logic [PW-1:0] position;
    logic          seq_error;

    int            total   = 0;
    int            bad     = 0;
    int            ev_seen = 0;
    int            err_seen = 0;
    int            bb_cnt  = 0;
    logic          prev_ev = 1'b0;
    logic [PW-1:0] pos_exp = '0;
    logic          dir_exp = 1'b0;
    vec_t          vt[10];

    rot_quad_decoder #(.DEBOUNCE_CYCLES(DC), .POS_WIDTH(PW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ROT_A          (rot_a),
        .ROT_B          (rot_b),
        .rotation_event (rotation_event),
        .rotation_dir   (rotation_dir),
        .position       (position),
        .seq_error      (seq_error)
    );

    always #5 clk = ~clk;

    // Pulse monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (rotation_event) ev_seen <= ev_seen + 1;
        if (seq_error) err_seen <= err_seen + 1;
        if (rotation_event && prev_ev) bb_cnt <= bb_cnt + 1;
        prev_ev <= rotation_event;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] code, input int n);
        rot_a = code[1];
        rot_b = code[0];
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] code);
        rot_a = code[1];
        rot_b = code[0];
        rst_n = 1'b0;
        #1;
        chk("reset_event", 32'(rotation_event), 32'd0);
        chk("reset_pos", 32'(position), 32'd0);
        chk("reset_dir", 32'(rotation_dir), 32'd0);
        chk("reset_err", 32'(seq_error), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        pos_exp = '0;
        dir_exp = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int e0;
        int r0;
        e0 = ev_seen;
        r0 = err_seen;
        for (int i = 0; i < v.len; i++) begin
            step(v.seq[15-2*i -: 2], HOLD);
        end
        if (v.ev != 0) dir_exp = v.dir;
        pos_exp = pos_exp + PW'(v.dpos);
        chk({nm, "_events"}, 32'(ev_seen - e0), 32'(v.ev));
        chk({nm, "_errors"}, 32'(err_seen - r0), 32'(v.err));
        chk({nm, "_pos"}, 32'(position), 32'(pos_exp));
        chk({nm, "_dir"}, 32'(rotation_dir), 32'(dir_exp));
    endtask

    initial begin
        int e0;
        int r0;

        vt[0] = '{16'b00_10_11_01_00_000000, 5, 1, 0,  1, 1'b1}; // CW detent
        vt[1] = '{16'b00_01_11_10_00_000000, 5, 1, 0, -1, 1'b0}; // CCW detent
        vt[2] = '{16'b00_10_00_0000000000,   3, 0, 0,  0, 1'b0}; // half step back
        vt[3] = '{16'b00_10_11_10_00_000000, 5, 0, 0,  0, 1'b0}; // CW partial back
        vt[4] = '{16'b00_11_00_0000000000,   3, 0, 1,  0, 1'b0}; // illegal jump
        vt[5] = '{16'b00_10_11_01_00_000000, 5, 1, 0,  1, 1'b1}; // CW after recovery
        vt[6] = '{16'b00_11_01_00_00000000,  4, 0, 1,  0, 1'b0}; // jump, no event in RESYNC
        vt[7] = '{16'b00_01_11_01_00_000000, 5, 0, 0,  0, 1'b0}; // CCW partial back
        vt[8] = '{16'b00_10_11_01_11_01_00_00, 7, 1, 0, 1, 1'b1}; // CW with backtrack
        vt[9] = '{16'b00_10_11_00_00000000,  4, 0, 1,  0, 1'b0}; // illegal from CW2

        // Reset release with pins at rest: RESYNC -> IDLE silently.
        do_reset(2'b00);
        e0 = ev_seen; r0 = err_seen;
        step(2'b00, HOLD + LAT);
        chk("rel00_events", 32'(ev_seen - e0), 32'd0);
        chk("rel00_errors", 32'(err_seen - r0), 32'd0);

        for (int k = 0; k < 10; k++) begin
            run_vec(vt[k], $sformatf("vec%0d", k));
        end

        // Exact event latency after the final rest code.
        step(2'b10, HOLD); step(2'b11, HOLD); step(2'b01, HOLD);
        rot_a = 1'b0; rot_b = 1'b0;
        for (int k = 1; k <= LAT + 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("lat_edge%0d", k), 32'(rotation_event), 32'(k == LAT + 1));
        end
        pos_exp = pos_exp + PW'(1); dir_exp = 1'b1;
        chk("lat_pos", 32'(position), 32'(pos_exp));

        // Reset mid-sequence, release on 01: a bare 00 must not give an event.
        step(2'b10, HOLD); step(2'b11, HOLD);
        do_reset(2'b01);
        e0 = ev_seen; r0 = err_seen;
        step(2'b01, HOLD); step(2'b00, HOLD);
        chk("midrst_events", 32'(ev_seen - e0), 32'd0);
        chk("midrst_errors", 32'(err_seen - r0), 32'd0);
        chk("midrst_pos", 32'(position), 32'd0);
        run_vec(vt[0], "midrst_cw");

        // Reset release with pins at 11: stays in RESYNC, silent.
        do_reset(2'b11);
        e0 = ev_seen; r0 = err_seen;
        step(2'b11, 2 * HOLD);
        step(2'b00, HOLD);
        chk("rel11_events", 32'(ev_seen - e0), 32'd0);
        chk("rel11_errors", 32'(err_seen - r0), 32'd0);
        run_vec(vt[0], "rel11_cw");

        // Glitch on A while in CCW3: filtered out only when debouncing.
        step(2'b01, HOLD); step(2'b11, HOLD); step(2'b10, HOLD);
        e0 = ev_seen;
        rot_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rot_a = 1'b1;
        repeat (HOLD) @(posedge clk);
        #1;
        chk("glitch_events", 32'(ev_seen - e0), 32'(GLITCH_EVENTS));
        step(2'b00, HOLD);
        pos_exp = pos_exp - PW'(1); dir_exp = 1'b0;
        chk("glitch_pos", 32'(position), 32'(pos_exp));
        chk("glitch_dir", 32'(rotation_dir), 32'(dir_exp));

`ifdef ROT_DEBOUNCE_EN
        // Chatter on B before the final rest code delays the filtered edge.
        step(2'b10, HOLD); step(2'b11, HOLD); step(2'b01, HOLD);
        step(2'b00, 1); step(2'b01, 1); step(2'b00, 1); step(2'b01, 1);
        rot_b = 1'b0;
        for (int k = 1; k <= LAT + 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("chat_edge%0d", k), 32'(rotation_event), 32'(k == LAT + 1));
        end
        pos_exp = pos_exp + PW'(1); dir_exp = 1'b1;
        chk("chat_pos", 32'(position), 32'(pos_exp));
`endif

        // Wrap: CCW from 0 gives all-ones, then 16 CW detents wrap through 0.
        do_reset(2'b00);
        step(2'b00, HOLD + LAT);
        run_vec(vt[1], "wrap_ccw");
        chk("wrap_ccw_is_f", 32'(position), 32'hF);
        for (int k = 0; k < 16; k++) begin
            run_vec(vt[0], $sformatf("wrap_cw%0d", k));
        end

        chk("no_back_to_back", 32'(bb_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
